// File: rtl/lut_sched_pkg.sv
// Shared types, constants and round-robin pick for the LUT operation scheduler.
// Pure definitions: no latency, no backpressure.
// Imported by the scheduler top and its NAND core.
package lut_sched_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Lowest set bit strictly above 'last', else lowest set bit overall (wrap).
    // Callers zero-extend to 8 requesters; unused lanes must be 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] last);
        logic [7:0] upper;
        logic [7:0] pool;
        logic [2:0] pick;
        upper = valid & ~((8'd2 << last) - 8'd1);
        pool  = (upper != 8'd0) ? upper : valid;
        pick  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pool[i]) pick = 3'(i);
        end
        return pick;
    endfunction

endpackage

// File: rtl/lut_nand_core.sv
// Registered bitwise NAND unit: y <= ~a | ~b on clock enable.
// Latency: 1 cycle from clk_e_i to y_o; output holds while clk_e_i is low.
// No backpressure: the caller owns when the enable fires.
module lut_nand_core
    import lut_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clk_e_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;

    always_comb begin
        y_d = y_q;
        if (clk_e_i) y_d = ~a_i | ~b_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) y_q <= '0;
        else         y_q <= y_d;
    end

    assign y_o = y_q;

endmodule

// File: rtl/lut_op_scheduler.sv
// Round-robin scheduler sharing one NAND core among N_REQ requesters.
// Latency: accept edge -> ISSUE -> RESP, 3 cycles minimum per transaction.
// Backpressure: RESP holds until rsp_ready_i; no new accepts until then.
module lut_op_scheduler
    import lut_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_a_i,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_b_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        rsp_valid_o,
    output logic [ID_W-1:0]             rsp_id_o,
    output logic [WIDTH-1:0]            rsp_data_o,
    input  logic                        rsp_ready_i,
    output logic                        busy_o,
    output logic [CNT_W-1:0]            ops_done_o
);

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic             any_vld;
    logic [ID_W-1:0]  grant;
    logic [N_REQ-1:0] grant_oh;
    logic             core_en;
    logic [WIDTH-1:0] core_y;

    // Accept strobe depends only on state and req_valid_i, never on rsp_ready_i.
    always_comb begin
        any_vld  = |req_valid_i;
        grant    = ID_W'(rr_pick(8'(req_valid_i), 3'(last_grant_q)));
        grant_oh = '0;
        if (state_q == ST_IDLE && any_vld) grant_oh[grant] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        ops_done_d   = ops_done_q;
        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    a_d          = req_a_i[grant];
                    b_d          = req_b_i[grant];
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready_i) begin
                    ops_done_d = ops_done_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign core_en = (state_q == ST_ISSUE);

    lut_nand_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clk_e_i (core_en),
        .a_i     (a_q),
        .b_i     (b_q),
        .y_o     (core_y)
    );

    assign req_ready_o = grant_oh;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = core_y;
    assign busy_o      = (state_q != ST_IDLE);
    assign ops_done_o  = ops_done_q;

endmodule

// File: tb/tb_lut_op_scheduler.sv
// Directed bench for lut_op_scheduler (N_REQ=2, WIDTH=4).
module tb_lut_op_scheduler;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic [1:0]      req_valid_i;
    logic [1:0][3:0] req_a_i;
    logic [1:0][3:0] req_b_i;
    logic [1:0]      req_ready_o;
    logic            rsp_valid_o;
    logic [0:0]      rsp_id_o;
    logic [3:0]      rsp_data_o;
    logic            rsp_ready_i;
    logic            busy_o;
    logic [15:0]     ops_done_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = 16'd0;

    always #5 clk_i = ~clk_i;

    lut_op_scheduler #(
        .N_REQ (2),
        .WIDTH (4)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_ready_i (rsp_ready_i),
        .busy_o      (busy_o),
        .ops_done_o  (ops_done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One transaction with rsp_ready_i high: IDLE accept, ISSUE, RESP handshake.
    task automatic do_txn(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_y);
        req_valid_i = 2'(1 << id);
        req_a_i[id] = a;
        req_b_i[id] = b;
        rsp_ready_i = 1'b1;
        #1;
        check("txn_rdy_oh", 32'(req_ready_o), 32'(1 << id));
        tick();
        req_valid_i = 2'b00;
        #1;
        check("txn_issue_busy", 32'(busy_o), 32'd1);
        check("txn_issue_rsp_vld", 32'(rsp_valid_o), 32'd0);
        check("txn_issue_rdy", 32'(req_ready_o), 32'd0);
        tick();
        check("txn_rsp_vld", 32'(rsp_valid_o), 32'd1);
        check("txn_rsp_id", 32'(rsp_id_o), 32'(id));
        check("txn_rsp_dat", 32'(rsp_data_o), 32'(exp_y));
        check("txn_cnt_pre", 32'(ops_done_o), 32'(exp_cnt));
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("txn_cnt_post", 32'(ops_done_o), 32'(exp_cnt));
        check("txn_idle_vld", 32'(rsp_valid_o), 32'd0);
        check("txn_idle_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i      = 1'b0;
        req_valid_i = 2'b00;
        req_a_i     = '0;
        req_b_i     = '0;
        rsp_ready_i = 1'b0;
        repeat (2) tick();
        check("rst_rdy", 32'(req_ready_o), 32'd0);
        check("rst_rsp_vld", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_id", 32'(rsp_id_o), 32'd0);
        check("rst_rsp_dat", 32'(rsp_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cnt", 32'(ops_done_o), 32'd0);
        rstn_i = 1'b1;
        tick();

        // Single request on requester 0.
        do_txn(0, 4'b1010, 4'b1100, 4'b0111);

        // Back-to-back sequence on requester 1.
        do_txn(1, 4'b1001, 4'b1100, 4'b0111);
        do_txn(1, 4'b1000, 4'b1001, 4'b0111);
        do_txn(1, 4'b1111, 4'b1101, 4'b0010);

        // Contention: both valid continuously; last grant was 1, so 0 goes first.
        req_a_i[0] = 4'b0011; req_b_i[0] = 4'b0101;
        req_a_i[1] = 4'b1111; req_b_i[1] = 4'b0110;
        req_valid_i = 2'b11;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_rdy_oh", 32'(req_ready_o), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check("cont_issue_rdy", 32'(req_ready_o), 32'd0);
            tick();
            check("cont_rsp_vld", 32'(rsp_valid_o), 32'd1);
            check("cont_rsp_id", 32'(rsp_id_o), 32'(k % 2));
            check("cont_rsp_dat", 32'(rsp_data_o), (k % 2 == 0) ? 32'hE : 32'h9);
            tick();
            exp_cnt = exp_cnt + 16'd1;
            check("cont_cnt", 32'(ops_done_o), 32'(exp_cnt));
        end
        req_valid_i = 2'b00;

        // Backpressure: hold RESP for 5 cycles while another requester waits.
        rsp_ready_i = 1'b0;
        req_valid_i = 2'b01;
        req_a_i[0]  = 4'b0110;
        req_b_i[0]  = 4'b0011;
        #1;
        check("bp_rdy_oh", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 2'b10;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_vld", 32'(rsp_valid_o), 32'd1);
            check("bp_rsp_id", 32'(rsp_id_o), 32'd0);
            check("bp_rsp_dat", 32'(rsp_data_o), 32'hD);
            check("bp_rdy", 32'(req_ready_o), 32'd0);
            check("bp_cnt_hold", 32'(ops_done_o), 32'(exp_cnt));
            tick();
        end
        req_valid_i = 2'b00;
        rsp_ready_i = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("bp_cnt", 32'(ops_done_o), 32'(exp_cnt));
        check("bp_done_vld", 32'(rsp_valid_o), 32'd0);

        // Reset while in ISSUE; last grant 0 so requester 1 is granted here.
        req_valid_i = 2'b10;
        req_a_i[1]  = 4'b1111;
        req_b_i[1]  = 4'b1101;
        #1;
        check("rsti_rdy_oh", 32'(req_ready_o), 32'd2);
        tick();
        check("rsti_busy", 32'(busy_o), 32'd1);
        rstn_i      = 1'b0;
        req_valid_i = 2'b00;
        tick();
        check("rsti_rsp_vld", 32'(rsp_valid_o), 32'd0);
        check("rsti_rdy", 32'(req_ready_o), 32'd0);
        check("rsti_rsp_id", 32'(rsp_id_o), 32'd0);
        check("rsti_rsp_dat", 32'(rsp_data_o), 32'd0);
        check("rsti_busy0", 32'(busy_o), 32'd0);
        check("rsti_cnt", 32'(ops_done_o), 32'd0);
        exp_cnt = 16'd0;
        rstn_i  = 1'b1;
        tick();
        check("rsti_no_rsp", 32'(rsp_valid_o), 32'd0);
        req_valid_i = 2'b11;
        #1;
        check("rsti_regrant0", 32'(req_ready_o), 32'd1);
        req_valid_i = 2'b00;
        tick();

        // Counter wrap from a preloaded value near the top.
        force dut.ops_done_q = 16'hFFFE;
        tick();
        release dut.ops_done_q;
        exp_cnt = 16'hFFFE;
        do_txn(0, 4'b0000, 4'b1111, 4'b1111);
        do_txn(1, 4'b1100, 4'b1010, 4'b0111);
        check("wrap_zero", 32'(ops_done_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
